write_sequencer: RTL and testbench

Controller that owns the write-program memory address and sequences the disc write engine. The host loads and steps the program address while the engine is idle. On a start command it hands the address to the engine and follows the engine's increment pulses. It reports completion, abort and address overflow through sticky status flags, and can force the engine into reset on abort. It sits between the host register interface, the program RAM address input and the write engine.

---
 rtl/write_sequencer.sv | 149 ++++++++++++++
 tb/tb_write_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_sequencer.sv
// rtl/write_sequencer.sv - program address owner and write engine sequencer
module write_sequencer #(
    parameter int ADDR_WIDTH    = 16,
    parameter int ABORT_CYCLES  = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic                  host_addr_load,
    input  logic                  host_addr_inc,
    input  logic                  cmd_start,
    input  logic                  cmd_abort,
    input  logic                  status_clr,
    input  logic                  wr_maddr_inc,
    input  logic                  wr_running,
    output logic                  wr_start,
    output logic                  wr_reset,
    output logic [ADDR_WIDTH-1:0] maddr,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  overflow,
    output logic                  start_err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_ABORT} state_t;

    localparam logic [7:0] START_LAST = 8'(START_TIMEOUT - 1);
    localparam logic [7:0] ABORT_INIT = 8'(ABORT_CYCLES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [7:0]            start_cnt_q, start_cnt_d;
    logic [7:0]            abort_cnt_q, abort_cnt_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  overflow_q, overflow_d;
    logic                  start_err_q, start_err_d;
    logic                  wr_start_q, wr_reset_q, busy_q;

    always_comb begin
        state_d     = state_q;
        maddr_d     = maddr_q;
        start_cnt_d = start_cnt_q;
        abort_cnt_d = abort_cnt_q;
        // Clear first so that any flag set below wins over status_clr.
        done_d      = status_clr ? 1'b0 : done_q;
        aborted_d   = status_clr ? 1'b0 : aborted_q;
        overflow_d  = status_clr ? 1'b0 : overflow_q;
        start_err_d = status_clr ? 1'b0 : start_err_q;

        case (state_q)
            S_IDLE: begin
                if (host_addr_load) begin
                    maddr_d = host_addr;
                end else if (host_addr_inc) begin
                    maddr_d = maddr_q + 1'b1;
                end
                if (!cmd_abort && cmd_start) begin
                    state_d     = S_START;
                    start_cnt_d = 8'd0;
                end
            end
            S_START: begin
                if (cmd_abort) begin
                    state_d     = S_ABORT;
                    abort_cnt_d = ABORT_INIT;
                end else if (wr_running) begin
                    state_d = S_RUN;
                end else if (start_cnt_q == START_LAST) begin
                    state_d     = S_ABORT;
                    abort_cnt_d = ABORT_INIT;
                    start_err_d = 1'b1;
                end else begin
                    start_cnt_d = start_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (wr_maddr_inc && (&maddr_q)) begin
                    maddr_d     = '0;
                    overflow_d  = 1'b1;
                    state_d     = S_ABORT;
                    abort_cnt_d = ABORT_INIT;
                end else begin
                    // The final engine increment may coincide with running dropping.
                    if (wr_maddr_inc) begin
                        maddr_d = maddr_q + 1'b1;
                    end
                    if (cmd_abort) begin
                        state_d     = S_ABORT;
                        abort_cnt_d = ABORT_INIT;
                    end else if (!wr_running) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ABORT: begin
                abort_cnt_d = abort_cnt_q - 8'd1;
                if (abort_cnt_q <= 8'd1) begin
                    abort_cnt_d = 8'd0;
                    state_d     = S_IDLE;
                    aborted_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are derived from the next state so every output is a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            maddr_q     <= '0;
            start_cnt_q <= 8'd0;
            abort_cnt_q <= 8'd0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            overflow_q  <= 1'b0;
            start_err_q <= 1'b0;
            wr_start_q  <= 1'b0;
            wr_reset_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            maddr_q     <= maddr_d;
            start_cnt_q <= start_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            overflow_q  <= overflow_d;
            start_err_q <= start_err_d;
            wr_start_q  <= (state_d == S_START);
            wr_reset_q  <= (state_d == S_ABORT);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign wr_start  = wr_start_q;
    assign wr_reset  = wr_reset_q;
    assign maddr     = maddr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign overflow  = overflow_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_write_sequencer.sv
// tb/tb_write_sequencer.sv - directed bench for write_sequencer
module tb_write_sequencer;

    logic        clock;
    logic        reset;
    logic [15:0] host_addr;
    logic        host_addr_load;
    logic        host_addr_inc;
    logic        cmd_start;
    logic        cmd_abort;
    logic        status_clr;
    logic        wr_maddr_inc;
    logic        wr_running;
    logic        wr_start;
    logic        wr_reset;
    logic [15:0] maddr;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        overflow;
    logic        start_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;

    write_sequencer #(
        .ADDR_WIDTH   (16),
        .ABORT_CYCLES (4),
        .START_TIMEOUT(8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .host_addr     (host_addr),
        .host_addr_load(host_addr_load),
        .host_addr_inc (host_addr_inc),
        .cmd_start     (cmd_start),
        .cmd_abort     (cmd_abort),
        .status_clr    (status_clr),
        .wr_maddr_inc  (wr_maddr_inc),
        .wr_running    (wr_running),
        .wr_start      (wr_start),
        .wr_reset      (wr_reset),
        .maddr         (maddr),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .overflow      (overflow),
        .start_err     (start_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic d, input logic a,
                             input logic o, input logic s);
        chk1({tag, "_done"}, done, d);
        chk1({tag, "_aborted"}, aborted, a);
        chk1({tag, "_overflow"}, overflow, o);
        chk1({tag, "_start_err"}, start_err, s);
    endtask

    task automatic count_wr_reset(output int c);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (!wr_reset) break;
            c++;
            cyc(1);
        end
    endtask

    initial begin
        reset          = 1'b0;
        host_addr      = 16'h0000;
        host_addr_load = 1'b0;
        host_addr_inc  = 1'b0;
        cmd_start      = 1'b0;
        cmd_abort      = 1'b0;
        status_clr     = 1'b0;
        wr_maddr_inc   = 1'b0;
        wr_running     = 1'b0;

        #12;
        chk1("rst_wr_reset", wr_reset, 1'b1);
        chk1("rst_wr_start", wr_start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_maddr", maddr, 16'h0000);
        chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1);
        chk1("rel_wr_reset", wr_reset, 1'b0);

        // Load and step
        host_addr      = 16'h1234;
        host_addr_load = 1'b1;
        cyc(1);
        host_addr_load = 1'b0;
        chk16("load_maddr", maddr, 16'h1234);
        host_addr_inc = 1'b1;
        cyc(3);
        host_addr_inc = 1'b0;
        chk16("step_maddr", maddr, 16'h1237);
        chk1("step_busy", busy, 1'b0);
        chk_flags("step", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load beats increment
        host_addr      = 16'h0010;
        host_addr_load = 1'b1;
        host_addr_inc  = 1'b1;
        cyc(1);
        host_addr_load = 1'b0;
        host_addr_inc  = 1'b0;
        chk16("ld_inc_maddr", maddr, 16'h0010);

        // Abort beats start in IDLE
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        chk1("st_ab_busy", busy, 1'b0);
        chk1("st_ab_wr_start", wr_start, 1'b0);
        cyc(1);
        chk1("st_ab_busy2", busy, 1'b0);
        chk1("st_ab_wr_reset", wr_reset, 1'b0);

        // Normal run: running rises two cycles after start is seen
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        chk1("run_busy", busy, 1'b1);
        chk1("run_ws1", wr_start, 1'b1);
        cyc(1);
        chk1("run_ws2", wr_start, 1'b1);
        cyc(1);
        chk1("run_ws3", wr_start, 1'b1);
        wr_running = 1'b1;
        cyc(1);
        chk1("run_ws_fall", wr_start, 1'b0);
        chk1("run_busy2", busy, 1'b1);
        wr_maddr_inc   = 1'b1;
        host_addr      = 16'hAAAA;
        host_addr_load = 1'b1;
        host_addr_inc  = 1'b1;
        cyc(4);
        host_addr_load = 1'b0;
        host_addr_inc  = 1'b0;
        chk16("run_host_ignored", maddr, 16'h0014);
        wr_running = 1'b0;
        status_clr = 1'b1;
        cyc(1);
        wr_maddr_inc = 1'b0;
        status_clr   = 1'b0;
        chk16("run_maddr", maddr, 16'h0015);
        chk1("run_end_busy", busy, 1'b0);
        chk_flags("run_end", 1'b1, 1'b0, 1'b0, 1'b0);
        status_clr = 1'b1;
        cyc(1);
        status_clr = 1'b0;
        chk1("clr_done", done, 1'b0);

        // Overflow
        host_addr      = 16'hFFFE;
        host_addr_load = 1'b1;
        cyc(1);
        host_addr_load = 1'b0;
        cmd_start      = 1'b1;
        cyc(1);
        cmd_start  = 1'b0;
        wr_running = 1'b1;
        cyc(1);
        wr_maddr_inc = 1'b1;
        cyc(1);
        chk16("ovf_maddr1", maddr, 16'hFFFF);
        chk1("ovf_flag_early", overflow, 1'b0);
        cyc(1);
        chk16("ovf_maddr_wrap", maddr, 16'h0000);
        chk1("ovf_flag", overflow, 1'b1);
        chk1("ovf_busy", busy, 1'b1);
        count_wr_reset(cnt);
        wr_maddr_inc = 1'b0;
        wr_running   = 1'b0;
        chk_int("ovf_wr_reset_cycles", cnt, 4);
        chk16("ovf_maddr_hold", maddr, 16'h0000);
        chk1("ovf_end_busy", busy, 1'b0);
        chk_flags("ovf_end", 1'b0, 1'b1, 1'b1, 1'b0);

        // Start timeout
        status_clr = 1'b1;
        cyc(1);
        status_clr = 1'b0;
        chk_flags("to_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!wr_start) break;
            cnt++;
            cyc(1);
        end
        chk_int("to_wr_start_cycles", cnt, 8);
        chk1("to_start_err", start_err, 1'b1);
        chk1("to_aborted_early", aborted, 1'b0);
        count_wr_reset(cnt);
        chk_int("to_wr_reset_cycles", cnt, 4);
        chk1("to_busy", busy, 1'b0);
        chk_flags("to_end", 1'b0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in RUN
        host_addr      = 16'h0100;
        host_addr_load = 1'b1;
        cyc(1);
        host_addr_load = 1'b0;
        cmd_start      = 1'b1;
        cyc(1);
        cmd_start  = 1'b0;
        wr_running = 1'b1;
        cyc(1);
        chk1("ar_busy_pre", busy, 1'b1);
        chk16("ar_maddr_pre", maddr, 16'h0100);
        #2;
        reset = 1'b0;
        #1;
        chk16("ar_maddr", maddr, 16'h0000);
        chk1("ar_wr_reset", wr_reset, 1'b1);
        chk1("ar_busy", busy, 1'b0);
        chk1("ar_wr_start", wr_start, 1'b0);
        chk_flags("ar", 1'b0, 1'b0, 1'b0, 1'b0);
        wr_running = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk1("ar_rel_wr_reset", wr_reset, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
